// File: rtl/fifo_sync_dut.sv
// Single-clock FIFO with registered read port, empty bypass and occupancy flags.
// Read data appears one enabled cycle after the read is accepted, qualified by valid_out.
module fifo_sync_dut #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       flush,
    input  logic                       wen_in,
    input  logic                       ren_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     num_words
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid;

    logic w_empty;
    logic w_full;
    logic w_active;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_bypass;
    logic w_do_wr;
    logic w_do_rd;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_active = clk_en & ~reset & ~flush;
    assign w_rd_acc = ren_in & (~w_empty | wen_in);
    assign w_wr_acc = wen_in & (~w_full | ren_in);
    // On an empty FIFO a simultaneous read/write passes data straight through.
    assign w_bypass = w_empty & ren_in & wen_in;
    assign w_do_wr  = w_active & w_wr_acc & ~w_bypass;
    assign w_do_rd  = w_active & w_rd_acc & ~w_empty;

    // Storage array carries no reset; stale entries are never addressed by a read.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_valid  <= 1'b0;
            end else begin
                r_valid <= w_rd_acc;
                if (w_bypass) begin
                    r_data_out <= data_in;
                end else if (w_do_rd) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
                if (w_do_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_do_rd) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_do_wr && !w_do_rd) begin
                    r_count <= r_count + 1'b1;
                end else if (w_do_rd && !w_do_wr) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid;
    assign empty     = w_empty;
    assign full      = w_full;
    assign num_words = r_count;

endmodule

// File: tb/tb_fifo_sync_dut.sv
// Scoreboard bench for fifo_sync_dut: a queue-based reference predicts the output
// state after every edge; a negedge monitor pops and compares each prediction.
module tb_fifo_sync_dut;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset, clk_en, flush, wen_in, ren_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out, empty, full;
    logic [AW:0]      num_words;

    always #5 clk = ~clk;

    fifo_sync_dut #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
        .wen_in(wen_in), .ren_in(ren_in), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .empty(empty),
        .full(full), .num_words(num_words)
    );

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        int               n;
    } exp_t;

    exp_t             sbq[$];
    logic [WIDTH-1:0] mq[$];
    logic             mv = 1'b0;
    logic [WIDTH-1:0] md = '0;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain queue holding the FIFO contents, oldest at the front.
    task automatic model(input logic rs, en, fl, w, r, input logic [WIDTH-1:0] d);
        bit is_empty, is_full, rd, wr;
        if (rs) begin
            mq.delete();
            mv = 1'b0;
            md = '0;
        end else if (en) begin
            if (fl) begin
                mq.delete();
                mv = 1'b0;
            end else begin
                is_empty = (mq.size() == 0);
                is_full  = (mq.size() == DEPTH);
                rd = r && (!is_empty || w);
                wr = w && (!is_full || r);
                if (is_empty && r && w) begin
                    md = d;
                end else begin
                    if (rd) md = mq.pop_front();
                    if (wr) mq.push_back(d);
                end
                mv = rd;
            end
        end
    endtask

    task automatic step(input logic rs, en, fl, w, r, input logic [WIDTH-1:0] d);
        exp_t e;
        reset = rs; clk_en = en; flush = fl; wen_in = w; ren_in = r; data_in = d;
        model(rs, en, fl, w, r, d);
        @(posedge clk);
        e.v = mv; e.d = md; e.n = mq.size();
        sbq.push_back(e);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("valid_out", 32'(valid_out), 32'(e.v));
                chk("data_out",  32'(data_out),  32'(e.d));
                chk("num_words", 32'(num_words), 32'(e.n));
                chk("empty",     32'(empty),     32'(e.n == 0));
                chk("full",      32'(full),      32'(e.n == DEPTH));
            end
        end
    end

    initial begin : stimulus
        int wprob, rprob;
        reset = 1'b1; clk_en = 1'b1; flush = 1'b0;
        wen_in = 1'b0; ren_in = 1'b0; data_in = '0;
        #1;
        // Reset held two cycles with a write pending.
        step(1, 1, 0, 1, 0, 16'hFFFF);
        step(1, 1, 0, 1, 0, 16'hFFFF);
        // Fill, overflow attempt, drain, underflow attempt.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, 0, WIDTH'(i));
        step(0, 1, 0, 1, 0, 16'hBEEF);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 1, '0);
        step(0, 1, 0, 0, 1, '0);
        // Empty bypass.
        step(0, 1, 0, 1, 1, 16'h1234);
        step(0, 1, 0, 0, 0, '0);
        // Full with simultaneous read/write, pointers wrapping.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, 0, WIDTH'(i));
        step(0, 1, 0, 1, 1, 16'h00AA);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 1, 1, WIDTH'(16'h0100 + i));
        // Down to five words, then clock-enable hold with toggling requests.
        for (int i = 0; i < DEPTH - 5; i++) step(0, 1, 0, 0, 1, '0);
        for (int k = 0; k < 3; k++) step(0, 0, k[0], ~k[0], k[1], WIDTH'(16'hC000 + k));
        step(0, 1, 1, 1, 0, 16'h5555);
        step(0, 1, 0, 0, 0, '0);
        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, WIDTH'(16'h0A00 + i));
        step(1, 1, 0, 1, 1, 16'h7777);
        step(0, 1, 0, 0, 1, '0);
        // Randomised traffic with shifting write/read bias.
        wprob = 50; rprob = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 200 == 0) begin
                wprob = 20 + 30 * int'($urandom_range(0, 2));
                rprob = 20 + 30 * int'($urandom_range(0, 2));
            end
            step(($urandom_range(0, 999) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < wprob),
                 ($urandom_range(0, 99) < rprob),
                 WIDTH'($urandom));
        end
        step(0, 1, 0, 0, 0, '0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
